// File: rtl/ccff_chain_loader_if.sv
// ----------------------------------------------------------------------------
// ccff_chain_loader_if
// Configuration-word stream between a bitstream source and the chain loader.
//   cfg_data  : configuration word, bit 0 is the first bit shifted into the chain
//   cfg_valid : cfg_data holds a word
//   cfg_ready : loader accepts the word on this cycle (cfg_valid & cfg_ready)
// Modports: master = bitstream source, slave = ccff_chain_loader.
// ----------------------------------------------------------------------------
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// ----------------------------------------------------------------------------
// ccff_chain_loader
// Serially programs one CB/SB configuration chain (ccff_head -> ccff_tail).
// Words arrive on a valid/ready stream, are serialised LSB first onto
// ccff_head, and ccff_shift_en gates the chain so it captures exactly
// CHAIN_LEN bits. Bits of the last word beyond CHAIN_LEN are discarded.
//
// Optional feature, macro CCFF_CHAIN_LOADER_VERIFY_EN:
//   after loading, the chain is recirculated for CHAIN_LEN cycles
//   (ccff_head follows ccff_tail) and a CRC-8 of the tail samples is
//   compared with a CRC-8 of the driven bits; a mismatch sets sticky error.
//   Without the macro there is no verify pass, error is 0, ccff_tail unused.
//
// Ports:
//   prog_clk      : programming clock, rising edge
//   prog_reset_n  : asynchronous active-low reset
//   start         : pulse, starts a load when idle
//   cfg           : configuration word stream (slave side)
//   ccff_head     : serial bit to chain head
//   ccff_shift_en : chain clock enable
//   ccff_tail     : chain tail (verify pass only)
//   busy          : load in progress
//   done          : one-cycle pulse at end of load
//   error         : sticky verify mismatch, cleared by next start
// ----------------------------------------------------------------------------
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 12,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                start,
  ccff_chain_loader_if.slave  cfg,
  output logic                ccff_head,
  output logic                ccff_shift_en,
  input  logic                ccff_tail,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int                IDX_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CHAIN_LEN);

`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
  localparam logic [CNT_W-1:0]  CNT_VLAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // CRC-8, polynomial x^8+x^2+x+1, one input bit per step
  function automatic logic [7:0] crc8_bit(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3
  } state_t;
`endif

  state_t            state_r;
  logic [WORD_W-1:0] word_r;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  idx_nxt_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic              cfg_ready_r;
  logic              head_r;
  logic              shift_en_r;
  logic              busy_r;
  logic              done_r;
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
  logic [7:0]        crc_tx_r;
  logic [7:0]        crc_rx_r;
  logic              verify_r;
  logic              error_r;
`endif

  assign idx_nxt_s = idx_r + IDX_W'(1);

  // Sequencer: word fetch, bit serialisation, optional verify, done pulse
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_r     <= ST_IDLE;
      word_r      <= '0;
      idx_r       <= '0;
      bit_cnt_r   <= '0;
      cfg_ready_r <= 1'b0;
      head_r      <= 1'b0;
      shift_en_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
      crc_tx_r    <= 8'h00;
      crc_rx_r    <= 8'h00;
      verify_r    <= 1'b0;
      error_r     <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_FETCH;
            busy_r      <= 1'b1;
            cfg_ready_r <= 1'b1;
            bit_cnt_r   <= '0;
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
            error_r     <= 1'b0;
            crc_tx_r    <= 8'h00;
            crc_rx_r    <= 8'h00;
`endif
          end
        end

        ST_FETCH: begin
          // The first bit of the new word goes out on the cycle after the handshake.
          if (cfg.cfg_valid && cfg_ready_r) begin
            state_r     <= ST_SHIFT;
            word_r      <= cfg.cfg_data;
            idx_r       <= '0;
            head_r      <= cfg.cfg_data[0];
            shift_en_r  <= 1'b1;
            cfg_ready_r <= 1'b0;
            bit_cnt_r   <= bit_cnt_r + CNT_W'(1);
          end
        end

        ST_SHIFT: begin
          // bit_cnt_r counts bits presented so far, including the one on head_r now.
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
          crc_tx_r <= crc8_bit(crc_tx_r, head_r);
`endif
          if (bit_cnt_r == CNT_LAST) begin
            head_r     <= 1'b0;
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
            // Keep shifting; the head now recirculates the tail.
            state_r    <= ST_VERIFY;
            verify_r   <= 1'b1;
            bit_cnt_r  <= '0;
`else
            state_r    <= ST_DONE;
            shift_en_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
`endif
          end else if (idx_r == IDX_LAST) begin
            state_r     <= ST_FETCH;
            cfg_ready_r <= 1'b1;
            shift_en_r  <= 1'b0;
            head_r      <= 1'b0;
          end else begin
            idx_r     <= idx_nxt_s;
            head_r    <= word_r[idx_nxt_s];
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          end
        end

`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
        ST_VERIFY: begin
          crc_rx_r  <= crc8_bit(crc_rx_r, ccff_tail);
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          if (bit_cnt_r == CNT_VLAST) begin
            state_r    <= ST_DONE;
            verify_r   <= 1'b0;
            shift_en_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            // Include the final tail sample in the comparison.
            error_r    <= (crc8_bit(crc_rx_r, ccff_tail) != crc_tx_r);
          end
        end
`endif

        ST_DONE: begin
          state_r <= ST_IDLE;
        end

        default: begin
          state_r     <= ST_IDLE;
          cfg_ready_r <= 1'b0;
          head_r      <= 1'b0;
          shift_en_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = cfg_ready_r;
  assign ccff_shift_en = shift_en_r;
  assign busy          = busy_r;
  assign done          = done_r;

`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
  // During verify the tail must reach the head in the same cycle to preserve contents.
  assign ccff_head = verify_r ? ccff_tail : head_r;
  assign error     = error_r;
`else
  logic unused_tail_s;
  assign unused_tail_s = ccff_tail;
  assign ccff_head     = head_r;
  assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ----------------------------------------------------------------------------
// tb_ccff_chain_loader
// Drives loads through ccff_chain_loader into a behavioural 12-flop chain
// and compares the shifted bit stream, chain contents and handshake/timing
// counts with values derived from the word values and the load rules.
// ----------------------------------------------------------------------------
module tb_ccff_chain_loader;
  localparam int CHAIN_LEN = 12;
  localparam int WORD_W    = 8;
  localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
  localparam int   VER_CYC   = CHAIN_LEN;
  localparam logic STUCK_ERR = 1'b1;
`else
  localparam int   VER_CYC   = 0;
  localparam logic STUCK_ERR = 1'b0;
`endif

  typedef struct {
    logic [7:0]           w0;
    logic [7:0]           w1;
    int                   stall;
    int                   mid_start;
    logic [CHAIN_LEN-1:0] exp_stream;
  } vec_t;

  logic prog_clk     = 1'b0;
  logic prog_reset_n = 1'b0;
  logic start        = 1'b0;
  logic ccff_head;
  logic ccff_shift_en;
  logic ccff_tail;
  logic busy;
  logic done;
  logic error;

  ccff_chain_loader_if #(.WORD_W(WORD_W)) cfg_if ();

  ccff_chain_loader #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) dut (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .start         (start),
    .cfg           (cfg_if),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 prog_clk = ~prog_clk;

  // Behavioural chain: head enters flop 0, tail is the last flop; optional stuck-at-0 flop.
  logic [CHAIN_LEN-1:0] chain_r = '0;
  logic [CHAIN_LEN-1:0] chain_nxt;
  int                   stuck_idx = -1;
  always @(posedge prog_clk) begin
    if (ccff_shift_en) begin
      chain_nxt = {chain_r[CHAIN_LEN-2:0], ccff_head};
      if (stuck_idx >= 0) chain_nxt[stuck_idx] = 1'b0;
      chain_r <= chain_nxt;
    end
  end
  assign ccff_tail = chain_r[CHAIN_LEN-1];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: the bit stream is the words concatenated LSB first, cut at CHAIN_LEN.
  function automatic logic [CHAIN_LEN-1:0] stream_of(input logic [7:0] w0, input logic [7:0] w1);
    logic [15:0] cat;
    cat = {w1, w0};
    return cat[CHAIN_LEN-1:0];
  endfunction

  // First bit shifted ends up in the tail flop.
  function automatic logic [CHAIN_LEN-1:0] chain_of(input logic [CHAIN_LEN-1:0] s);
    logic [CHAIN_LEN-1:0] r;
    for (int i = 0; i < CHAIN_LEN; i++) r[i] = s[CHAIN_LEN-1-i];
    return r;
  endfunction

  int          shift_cnt;
  int          hs_cnt;
  int          done_cnt;
  int          busy_cnt;
  logic [63:0] head_bits;

  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input int stall,
                          input int mid_start, input int rst_at_shift, input logic chk_chain,
                          input logic exp_err, input logic [CHAIN_LEN-1:0] exp_stream);
    logic [7:0] words [0:1];
    int         widx;
    int         stall_left;
    int         cyc;
    logic       finished;
    logic       aborted;
    words[0] = w0;  words[1] = w1;
    widx = 0;  stall_left = stall;  cyc = 0;  finished = 1'b0;  aborted = 1'b0;
    shift_cnt = 0;  hs_cnt = 0;  done_cnt = 0;  busy_cnt = 0;  head_bits = '0;
    @(negedge prog_clk);
    start = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    while (!finished && !aborted && cyc < 200) begin
      @(negedge prog_clk);
      start = (cyc == mid_start) ? 1'b1 : 1'b0;
      if (cyc == 0) check("error_clr_on_start", {31'd0, error}, 32'd0);
      cyc++;
      if (busy) busy_cnt++;
      if (ccff_shift_en) begin
        if (shift_cnt < 64) head_bits[shift_cnt] = ccff_head;
        shift_cnt++;
      end
      if (done) begin
        done_cnt++;
        finished = 1'b1;
      end
      if (rst_at_shift >= 0 && shift_cnt == rst_at_shift) begin
        prog_reset_n = 1'b0;
        #1;
        check("reset_mid_load_outputs",
              {26'd0, cfg_if.cfg_ready, ccff_head, ccff_shift_en, busy, done, error}, 32'd0);
        aborted = 1'b1;
      end else if (widx == 1 && stall_left > 0 && cfg_if.cfg_ready) begin
        cfg_if.cfg_valid = 1'b0;
        stall_left--;
      end else begin
        // Keep valid high with junk after the needed words to expose extra handshakes.
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = (widx < 2) ? words[widx] : 8'($urandom);
        if (cfg_if.cfg_ready) begin
          hs_cnt++;
          widx++;
        end
      end
    end
    start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    if (aborted) begin
      @(negedge prog_clk);
      prog_reset_n = 1'b1;
    end else begin
      check("load_completes", {31'd0, finished}, 32'd1);
      repeat (3) begin
        @(negedge prog_clk);
        if (done) done_cnt++;
        if (ccff_shift_en) shift_cnt++;
      end
      check("head_stream", 32'(head_bits[CHAIN_LEN-1:0]), 32'(exp_stream));
`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
      if (chk_chain) check("head_recirc", 32'(head_bits[2*CHAIN_LEN-1:CHAIN_LEN]), 32'(exp_stream));
`endif
      check("shift_cycles", shift_cnt, CHAIN_LEN + VER_CYC);
      check("handshakes", hs_cnt, N_WORDS);
      check("done_pulses", done_cnt, 1);
      check("busy_cycles", busy_cnt, CHAIN_LEN + N_WORDS + stall + VER_CYC);
      if (chk_chain) check("chain_contents", 32'(chain_r), 32'(chain_of(exp_stream)));
      check("error_flag", {31'd0, error}, {31'd0, exp_err});
    end
  endtask

  vec_t vecs [0:5];

  initial begin
    vecs[0] = '{w0: 8'hA5, w1: 8'h03, stall: 0, mid_start: -1, exp_stream: 12'h3A5};
    vecs[1] = '{w0: 8'hA5, w1: 8'h03, stall: 5, mid_start: -1, exp_stream: 12'h3A5};
    vecs[2] = '{w0: 8'hA5, w1: 8'h03, stall: 0, mid_start: 4,  exp_stream: 12'h3A5};
    vecs[3] = '{w0: 8'hFF, w1: 8'hF0, stall: 0, mid_start: -1, exp_stream: 12'h0FF};
    vecs[4] = '{w0: 8'h00, w1: 8'hFF, stall: 2, mid_start: 9,  exp_stream: 12'hF00};
    vecs[5] = '{w0: 8'h3C, w1: 8'hA9, stall: 1, mid_start: -1, exp_stream: 12'h93C};

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = 8'h00;
    repeat (2) @(negedge prog_clk);
    check("reset_state", {26'd0, cfg_if.cfg_ready, ccff_head, ccff_shift_en, busy, done, error}, 32'd0);
    prog_reset_n = 1'b1;
    @(negedge prog_clk);
    check("idle_after_reset", {26'd0, cfg_if.cfg_ready, ccff_head, ccff_shift_en, busy, done, error}, 32'd0);

    for (int i = 0; i < 6; i++)
      run_load(vecs[i].w0, vecs[i].w1, vecs[i].stall, vecs[i].mid_start, -1, 1'b1, 1'b0,
               vecs[i].exp_stream);

    // Reset during shifting, then a clean reload.
    run_load(8'hA5, 8'h03, 0, -1, 6, 1'b1, 1'b0, 12'h3A5);
    run_load(8'h5A, 8'h0C, 0, -1, -1, 1'b1, 1'b0, stream_of(8'h5A, 8'h0C));

    // Stuck-at-0 flop with an all-ones configuration; error must stick until next start.
    stuck_idx = 5;
    run_load(8'hFF, 8'h0F, 0, -1, -1, 1'b0, STUCK_ERR, 12'hFFF);
    repeat (2) @(negedge prog_clk);
    check("error_sticky", {31'd0, error}, {31'd0, STUCK_ERR});
    stuck_idx = -1;
    run_load(8'hA5, 8'h03, 0, -1, -1, 1'b1, 1'b0, 12'h3A5);

    for (int r = 0; r < 8; r++) begin
      logic [7:0] rw0;
      logic [7:0] rw1;
      int         rst;
      rw0 = 8'($urandom);
      rw1 = 8'($urandom);
      rst = int'($urandom_range(0, 3));
      run_load(rw0, rw1, rst, -1, -1, 1'b1, 1'b0, stream_of(rw0, rw1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
